// File: rtl/fpga_cfg_loader.sv
// Bitstream loader for the fpga fabric: streams config words into tiles
// one at a time, then sequences ff_en and rdy after programmable settles.
module fpga_cfg_loader #(
  parameter int CFG_W       = 224,
  parameter int NUM_TILES   = 43,
  parameter int PRE_CYCLES  = 10,
  parameter int POST_CYCLES = 10,
  parameter int RDY_DELAY   = 10
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 cfg_valid,
  input  logic [CFG_W-1:0]     cfg_data,
  output logic                 cfg_ready,
  output logic [CFG_W-1:0]     configs_in,
  output logic [NUM_TILES-1:0] configs_en,
  output logic                 ff_en,
  output logic                 rdy,
  output logic                 busy,
  output logic                 err
);

  localparam int MAX_A = (PRE_CYCLES > POST_CYCLES) ? PRE_CYCLES : POST_CYCLES;
  localparam int MAX_D = (MAX_A > RDY_DELAY) ? MAX_A : RDY_DELAY;
  localparam int CNT_W = (MAX_D > 1) ? $clog2(MAX_D) : 1;
  localparam int IDX_W = (NUM_TILES > 0) ? $clog2(NUM_TILES + 1) : 1;

  localparam logic [CNT_W-1:0] PRE_LD  = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] POST_LD = CNT_W'(POST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RDY_LD  = CNT_W'(RDY_DELAY - 1);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(NUM_TILES - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_POST = 3'd4;
  localparam logic [2:0] S_ARM  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             cnt_zero;

  assign cnt_zero  = (cnt == '0);
  assign cfg_ready = (state == S_LOAD);
  assign busy      = (state == S_PRE)  || (state == S_LOAD) ||
                     (state == S_HOLD) || (state == S_POST) ||
                     (state == S_ARM);

  // Load sequencer: walks the one-hot enable, then times ff_en and rdy.
  always_ff @(posedge clock) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      configs_in <= '0;
      configs_en <= '0;
      ff_en      <= 1'b0;
      rdy        <= 1'b0;
      err        <= 1'b0;
    end else if (abort) begin
      state      <= S_IDLE;
      configs_en <= '0;
      ff_en      <= 1'b0;
      rdy        <= 1'b0;
    end else begin
      if (start && busy)
        err <= 1'b1;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state <= S_PRE;
            cnt   <= PRE_LD;
            idx   <= '0;
            ff_en <= 1'b0;
            rdy   <= 1'b0;
            err   <= 1'b0;
          end
        end
        S_PRE: begin
          if (cnt_zero) begin
            configs_en <= NUM_TILES'(1);
            state      <= S_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_LOAD: begin
          if (cfg_valid) begin
            configs_in <= cfg_data;
            state      <= S_HOLD;
          end
        end
        S_HOLD: begin
          configs_en <= configs_en << 1;
          idx        <= idx + 1'b1;
          if (idx == LAST) begin
            state <= S_POST;
            cnt   <= POST_LD;
          end else begin
            state <= S_LOAD;
          end
        end
        S_POST: begin
          if (cnt_zero) begin
            ff_en <= 1'b1;
            state <= S_ARM;
            cnt   <= RDY_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_ARM: begin
          if (cnt_zero) begin
            rdy   <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Self-checking bench for fpga_cfg_loader: directed scenarios plus
// randomized loads checked against a timeline derived from the delays.
module tb_fpga_cfg_loader;

  localparam int CW   = 8;
  localparam int NT   = 3;
  localparam int PRE  = 2;
  localparam int POST = 3;
  localparam int RDYD = 2;

  logic          clock = 1'b0;
  logic          rst, start, abort, cfg_valid;
  logic [CW-1:0] cfg_data;
  logic          cfg_ready;
  logic [CW-1:0] configs_in;
  logic [NT-1:0] configs_en;
  logic          ff_en, rdy, busy, err;

  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] exp_in;
  logic          exp_err;

  fpga_cfg_loader #(
    .CFG_W(CW), .NUM_TILES(NT), .PRE_CYCLES(PRE),
    .POST_CYCLES(POST), .RDY_DELAY(RDYD)
  ) dut (
    .clock(clock), .rst(rst), .start(start), .abort(abort),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .configs_in(configs_in),
    .configs_en(configs_en), .ff_en(ff_en), .rdy(rdy),
    .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NT-1:0] onehot(input int i);
    return NT'(1 << i);
  endfunction

  // Start pulse from IDLE/DONE, then the PRE window; ends in LOAD.
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_err = 1'b0;
    check("start_busy", busy, 1);
    check("start_ffen", ff_en, 0);
    check("start_rdy", rdy, 0);
    check("start_err", err, 0);
    check("start_ready", cfg_ready, 0);
    check("start_en", configs_en, 0);
    check("start_in", configs_in, exp_in);
    for (int c = 1; c < PRE; c++) begin
      tick();
      check("pre_ready", cfg_ready, 0);
      check("pre_busy", busy, 1);
    end
    tick();
    check("load_ready", cfg_ready, 1);
    check("load_en", configs_en, onehot(0));
  endtask

  // Present word i after a stall; ends in the HOLD cycle.
  task automatic feed(input int i, input logic [CW-1:0] w, input int st);
    for (int s = 0; s < st; s++) begin
      cfg_valid = 1'b0;
      cfg_data = CW'($urandom);
      check("stall_ready", cfg_ready, 1);
      check("stall_en", configs_en, onehot(i));
      check("stall_in", configs_in, exp_in);
      tick();
    end
    check("acc_ready", cfg_ready, 1);
    check("acc_en", configs_en, onehot(i));
    cfg_valid = 1'b1;
    cfg_data = w;
    tick();
    exp_in = w;
    check("hold_ready", cfg_ready, 0);
    check("hold_in", configs_in, exp_in);
    check("hold_en", configs_en, onehot(i));
    check("hold_busy", busy, 1);
    cfg_data = CW'($urandom);
  endtask

  task automatic hold_exit(input int i);
    tick();
    cfg_valid = 1'b0;
    if (i < NT - 1) begin
      check("next_en", configs_en, onehot(i + 1));
      check("next_ready", cfg_ready, 1);
      check("next_in", configs_in, exp_in);
    end
  endtask

  // POST and ARM windows after the last HOLD; ends in DONE.
  task automatic finish_load(input bit poke);
    check("post_en", configs_en, 0);
    check("post_busy", busy, 1);
    check("post_ffen", ff_en, 0);
    for (int k = 1; k < POST; k++) begin
      if (poke && k == 1) start = 1'b1;
      tick();
      start = 1'b0;
      if (poke) exp_err = 1'b1;
      check("post_wait_ffen", ff_en, 0);
      check("post_wait_busy", busy, 1);
      check("post_err", err, exp_err);
    end
    tick();
    check("arm_ffen", ff_en, 1);
    check("arm_rdy", rdy, 0);
    check("arm_busy", busy, 1);
    for (int k = 1; k < RDYD; k++) begin
      tick();
      check("arm_wait_rdy", rdy, 0);
      check("arm_wait_busy", busy, 1);
    end
    tick();
    check("done_rdy", rdy, 1);
    check("done_busy", busy, 0);
    check("done_ffen", ff_en, 1);
    check("done_en", configs_en, 0);
    check("done_in", configs_in, exp_in);
    check("done_err", err, exp_err);
    check("done_ready", cfg_ready, 0);
  endtask

  task automatic full_load(input logic [CW-1:0] w0, input logic [CW-1:0] w1,
                           input logic [CW-1:0] w2, input int s0,
                           input int s1, input int s2, input bit poke);
    do_start();
    feed(0, w0, s0);
    hold_exit(0);
    feed(1, w1, s1);
    hold_exit(1);
    feed(2, w2, s2);
    hold_exit(2);
    finish_load(poke);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    cfg_valid = 1'b0;
    cfg_data = '0;
    exp_in = '0;
    exp_err = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_ready", cfg_ready, 0);
    check("rst_in", configs_in, 0);
    check("rst_en", configs_en, 0);
    check("rst_ffen", ff_en, 0);
    check("rst_rdy", rdy, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);

    // basic load with cfg_valid held high
    full_load(8'hA1, 8'hB2, 8'hC3, 0, 0, 0, 1'b0);
    // restart from DONE, stall before word 2, start poked in POST
    full_load(8'hA1, 8'hB2, 8'hC3, 0, 5, 0, 1'b1);
    check("err_sticky_done", err, 1);

    for (int r = 0; r < 4; r++) begin
      full_load(CW'($urandom), CW'($urandom), CW'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // abort beats start while in DONE
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("abdone_ffen", ff_en, 0);
    check("abdone_rdy", rdy, 0);
    check("abdone_busy", busy, 0);
    check("abdone_err", err, exp_err);
    check("abdone_in", configs_in, exp_in);
    tick();
    check("abdone_idle", busy, 0);

    // abort in HOLD of word 2
    do_start();
    feed(0, 8'hA1, 0);
    hold_exit(0);
    feed(1, 8'hB2, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    cfg_valid = 1'b0;
    check("ab_en", configs_en, 0);
    check("ab_ready", cfg_ready, 0);
    check("ab_ffen", ff_en, 0);
    check("ab_rdy", rdy, 0);
    check("ab_busy", busy, 0);
    check("ab_in", configs_in, 8'hB2);
    tick();
    check("ab_stay_ready", cfg_ready, 0);

    // reset during LOAD with err set
    do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_err", err, 1);
    check("busy_start_ready", cfg_ready, 1);
    check("busy_start_en", configs_en, onehot(0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_ready", cfg_ready, 0);
    check("rst2_in", configs_in, 0);
    check("rst2_en", configs_en, 0);
    check("rst2_ffen", ff_en, 0);
    check("rst2_rdy", rdy, 0);
    check("rst2_busy", busy, 0);
    check("rst2_err", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
